// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// CNT_W-wide up-counter that sticks at all-ones; synchronous active-high reset.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, branch
// squashes and data-memory wait handling with timeout, plus perf counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs_ID,
    input  logic [4:0]       rt_ID,
    input  logic             uses_rs_ID,
    input  logic             uses_rt_ID,
    input  logic [4:0]       rd_EX,
    input  logic             mem_rd_EX,
    input  logic             branch_taken_EX,
    input  logic             mem_rd_MEM,
    input  logic             mem_wr_MEM,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             en_PC,
    output logic             en_IF_ID,
    output logic             en_ID_EX,
    output logic             en_EX_MEM,
    output logic             en_MEM_WB,
    output logic             flush_IF_ID,
    output logic             flush_ID_EX,
    output logic             flush_MEM_WB,
    output logic             dmem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt
);

    localparam int unsigned TW = $clog2(TIMEOUT);

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            err_q, err_d;
    logic            mem_access;
    logic            load_use;
    logic            apply_hazards;
    logic            inc_stall, inc_flush, inc_wait;

    always_comb begin
        mem_access = mem_rd_MEM | mem_wr_MEM;
        load_use   = mem_rd_EX && (rd_EX != REG_ZERO) &&
                     ((uses_rs_ID && (rs_ID == rd_EX)) ||
                      (uses_rt_ID && (rt_ID == rd_EX)));
    end

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        err_d         = err_q;
        dmem_req      = 1'b0;
        en_PC         = 1'b1;
        en_IF_ID      = 1'b1;
        en_ID_EX      = 1'b1;
        en_EX_MEM     = 1'b1;
        en_MEM_WB     = 1'b1;
        flush_IF_ID   = 1'b0;
        flush_ID_EX   = 1'b0;
        flush_MEM_WB  = 1'b0;
        inc_stall     = 1'b0;
        inc_flush     = 1'b0;
        inc_wait      = 1'b0;
        apply_hazards = 1'b0;

        case (state_q)
            ST_RUN: begin
                dmem_req = mem_access;
                if (mem_access && !dmem_ready) begin
                    {en_PC, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB} = '0;
                    state_d = ST_MEM_WAIT;
                    timer_d = TW'(1);
                end else begin
                    apply_hazards = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                dmem_req = 1'b1;
                inc_wait = 1'b1;
                if (dmem_ready) begin
                    state_d       = ST_RUN;
                    timer_d       = '0;
                    apply_hazards = 1'b1;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    err_d         = 1'b1;
                    flush_MEM_WB  = 1'b1;
                    state_d       = ST_RUN;
                    timer_d       = '0;
                    apply_hazards = 1'b1;
                end else begin
                    {en_PC, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB} = '0;
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = ST_RUN;
        endcase

        // Branch wins over load-use: the dependent instruction is squashed anyway.
        if (apply_hazards) begin
            if (branch_taken_EX) begin
                flush_IF_ID = 1'b1;
                flush_ID_EX = 1'b1;
                inc_flush   = 1'b1;
            end else if (load_use) begin
                en_PC       = 1'b0;
                en_IF_ID    = 1'b0;
                flush_ID_EX = 1'b1;
                inc_stall   = 1'b1;
            end
        end

        if (reset) begin
            dmem_req = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end

    assign dmem_err = err_q;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_stall),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_flush),
        .count (flush_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_wait),
        .count (wait_cnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (TIMEOUT=4, CNT_W=4).
module tb_pipeline_ctrl;

    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned CNT_W   = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       rs_ID, rt_ID, rd_EX;
    logic             uses_rs_ID, uses_rt_ID, mem_rd_EX, branch_taken_EX;
    logic             mem_rd_MEM, mem_wr_MEM, dmem_ready;
    logic             dmem_req;
    logic             en_PC, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB;
    logic             flush_IF_ID, flush_ID_EX, flush_MEM_WB;
    logic             dmem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt, wait_cnt;

    logic [4:0] en_v;
    logic [2:0] fl_v;
    assign en_v = {en_PC, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB};
    assign fl_v = {flush_IF_ID, flush_ID_EX, flush_MEM_WB};

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .rs_ID           (rs_ID),
        .rt_ID           (rt_ID),
        .uses_rs_ID      (uses_rs_ID),
        .uses_rt_ID      (uses_rt_ID),
        .rd_EX           (rd_EX),
        .mem_rd_EX       (mem_rd_EX),
        .branch_taken_EX (branch_taken_EX),
        .mem_rd_MEM      (mem_rd_MEM),
        .mem_wr_MEM      (mem_wr_MEM),
        .dmem_ready      (dmem_ready),
        .dmem_req        (dmem_req),
        .en_PC           (en_PC),
        .en_IF_ID        (en_IF_ID),
        .en_ID_EX        (en_ID_EX),
        .en_EX_MEM       (en_EX_MEM),
        .en_MEM_WB       (en_MEM_WB),
        .flush_IF_ID     (flush_IF_ID),
        .flush_ID_EX     (flush_ID_EX),
        .flush_MEM_WB    (flush_MEM_WB),
        .dmem_err        (dmem_err),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
        .wait_cnt        (wait_cnt)
    );

    // Inputs change 1 time unit after a rising edge; outputs are sampled 4 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs_ID = '0; rt_ID = '0; rd_EX = '0;
        uses_rs_ID = 0; uses_rt_ID = 0; mem_rd_EX = 0; branch_taken_EX = 0;
        mem_rd_MEM = 0; mem_wr_MEM = 0; dmem_ready = 0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] r);
        mem_rd_EX = 1; rd_EX = r; rs_ID = r; uses_rs_ID = 1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        tick();
        tick();
        mem_wr_MEM = 1;
        #4;
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", dmem_req); end
        checks++; if (dmem_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", dmem_err); end
        checks++; if ({stall_cnt, flush_cnt, wait_cnt} !== '0) begin errors++; $display("FAIL reset_cnts: got %h expected 0", {stall_cnt, flush_cnt, wait_cnt}); end
        tick();
        reset = 1'b0;
        idle();
        #4;
        checks++; if (en_v !== 5'b11111) begin errors++; $display("FAIL reset_en: got %b expected 11111", en_v); end
        checks++; if (fl_v !== 3'b000) begin errors++; $display("FAIL reset_flush: got %b expected 000", fl_v); end
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_state: got req %b expected 0", dmem_req); end
    endtask

    task automatic test_load_use();
        apply_reset();
        set_load_use(5'd8);
        #4;
        checks++; if (en_v !== 5'b00111) begin errors++; $display("FAIL lu_en: got %b expected 00111", en_v); end
        checks++; if (fl_v !== 3'b010) begin errors++; $display("FAIL lu_flush: got %b expected 010", fl_v); end
        tick();
        idle();
        #4;
        checks++; if (en_v !== 5'b11111) begin errors++; $display("FAIL lu_one_cycle: got %b expected 11111", en_v); end
        checks++; if (stall_cnt !== 4'd1) begin errors++; $display("FAIL lu_cnt: got %0d expected 1", stall_cnt); end
        tick();
        set_load_use(5'd0);
        #4;
        checks++; if (en_v !== 5'b11111 || fl_v !== 3'b000) begin errors++; $display("FAIL lu_r0: got en %b fl %b expected 11111 000", en_v, fl_v); end
        tick();
        idle();
        mem_rd_EX = 1; rd_EX = 5'd9; rt_ID = 5'd9; uses_rt_ID = 1; rs_ID = 5'd3; uses_rs_ID = 1;
        #4;
        checks++; if (en_v !== 5'b00111) begin errors++; $display("FAIL lu_rt: got %b expected 00111", en_v); end
        tick();
        uses_rt_ID = 0;
        #4;
        checks++; if (en_v !== 5'b11111) begin errors++; $display("FAIL lu_rt_unused: got %b expected 11111", en_v); end
        tick();
        idle();
        mem_rd_EX = 0; rd_EX = 5'd4; rs_ID = 5'd4; uses_rs_ID = 1;
        #4;
        checks++; if (en_v !== 5'b11111) begin errors++; $display("FAIL lu_not_load: got %b expected 11111", en_v); end
        tick();
        idle();
        #4;
        checks++; if (stall_cnt !== 4'd2) begin errors++; $display("FAIL lu_cnt2: got %0d expected 2", stall_cnt); end
    endtask

    task automatic test_branch_priority();
        apply_reset();
        set_load_use(5'd8);
        branch_taken_EX = 1;
        #4;
        checks++; if (en_v !== 5'b11111) begin errors++; $display("FAIL br_en: got %b expected 11111", en_v); end
        checks++; if (fl_v !== 3'b110) begin errors++; $display("FAIL br_flush: got %b expected 110", fl_v); end
        tick();
        idle();
        #4;
        checks++; if (flush_cnt !== 4'd1) begin errors++; $display("FAIL br_fcnt: got %0d expected 1", flush_cnt); end
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL br_scnt: got %0d expected 0", stall_cnt); end
    endtask

    task automatic test_mem_wait();
        apply_reset();
        mem_wr_MEM = 1;
        for (int i = 0; i < 3; i++) begin
            #4;
            checks++; if (dmem_req !== 1'b1 || en_v !== 5'b00000) begin errors++; $display("FAIL wait_frozen[%0d]: got req %b en %b expected 1 00000", i, dmem_req, en_v); end
            tick();
        end
        dmem_ready = 1;
        #4;
        checks++; if (dmem_req !== 1'b1 || en_v !== 5'b11111 || fl_v !== 3'b000) begin errors++; $display("FAIL wait_release: got req %b en %b fl %b expected 1 11111 000", dmem_req, en_v, fl_v); end
        tick();
        idle();
        #4;
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL wait_back_run: got req %b expected 0", dmem_req); end
        checks++; if (wait_cnt !== 4'd3) begin errors++; $display("FAIL wait_cnt: got %0d expected 3", wait_cnt); end
        checks++; if (dmem_err !== 1'b0) begin errors++; $display("FAIL wait_err: got %b expected 0", dmem_err); end
        tick();
        mem_rd_MEM = 1; dmem_ready = 1;
        #4;
        checks++; if (dmem_req !== 1'b1 || en_v !== 5'b11111) begin errors++; $display("FAIL zero_stall: got req %b en %b expected 1 11111", dmem_req, en_v); end
        tick();
        idle();
        #4;
        checks++; if (wait_cnt !== 4'd3) begin errors++; $display("FAIL zero_stall_cnt: got %0d expected 3", wait_cnt); end
    endtask

    task automatic test_timeout();
        apply_reset();
        mem_rd_MEM = 1;
        for (int i = 0; i < 3; i++) begin
            #4;
            checks++; if (en_v !== 5'b00000) begin errors++; $display("FAIL to_frozen[%0d]: got %b expected 00000", i, en_v); end
            tick();
        end
        #4;
        checks++; if (en_v !== 5'b11111 || fl_v !== 3'b001) begin errors++; $display("FAIL to_release: got en %b fl %b expected 11111 001", en_v, fl_v); end
        checks++; if (dmem_err !== 1'b0) begin errors++; $display("FAIL to_err_early: got %b expected 0", dmem_err); end
        tick();
        idle();
        #4;
        checks++; if (dmem_err !== 1'b1) begin errors++; $display("FAIL to_err: got %b expected 1", dmem_err); end
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL to_back_run: got req %b expected 0", dmem_req); end
        checks++; if (wait_cnt !== 4'd3) begin errors++; $display("FAIL to_wcnt: got %0d expected 3", wait_cnt); end
        tick(); tick(); tick();
        #4;
        checks++; if (dmem_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b expected 1", dmem_err); end
        tick();
        apply_reset();
        #4;
        checks++; if (dmem_err !== 1'b0) begin errors++; $display("FAIL to_clear: got %b expected 0", dmem_err); end
    endtask

    task automatic test_branch_in_wait();
        apply_reset();
        mem_wr_MEM = 1; branch_taken_EX = 1;
        for (int i = 0; i < 2; i++) begin
            #4;
            checks++; if (fl_v !== 3'b000 || en_v !== 5'b00000) begin errors++; $display("FAIL bw_frozen[%0d]: got fl %b en %b expected 000 00000", i, fl_v, en_v); end
            tick();
        end
        dmem_ready = 1;
        #4;
        checks++; if (fl_v !== 3'b110 || en_v !== 5'b11111) begin errors++; $display("FAIL bw_release: got fl %b en %b expected 110 11111", fl_v, en_v); end
        tick();
        idle();
        #4;
        checks++; if (flush_cnt !== 4'd1) begin errors++; $display("FAIL bw_fcnt: got %0d expected 1", flush_cnt); end
        checks++; if (wait_cnt !== 4'd2) begin errors++; $display("FAIL bw_wcnt: got %0d expected 2", wait_cnt); end
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        mem_wr_MEM = 1;
        tick();
        #4;
        checks++; if (dmem_req !== 1'b1 || en_v !== 5'b00000) begin errors++; $display("FAIL rm_wait: got req %b en %b expected 1 00000", dmem_req, en_v); end
        tick();
        reset = 1'b1;
        #4;
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rm_req_low: got %b expected 0", dmem_req); end
        tick();
        reset = 1'b0;
        idle();
        #4;
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rm_state_run: got req %b expected 0", dmem_req); end
        checks++; if (wait_cnt !== 4'd0 || dmem_err !== 1'b0) begin errors++; $display("FAIL rm_clear: got wcnt %0d err %b expected 0 0", wait_cnt, dmem_err); end
    endtask

    task automatic test_saturation();
        apply_reset();
        set_load_use(5'd12);
        for (int i = 0; i < 14; i++) tick();
        #4;
        checks++; if (stall_cnt !== 4'd14) begin errors++; $display("FAIL sat_mid: got %0d expected 14", stall_cnt); end
        tick();
        for (int i = 0; i < 6; i++) tick();
        idle();
        #4;
        checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d expected 15", stall_cnt); end
        tick();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_priority();
        test_mem_wait();
        test_timeout();
        test_branch_in_wait();
        test_reset_mid_wait();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
